// File: rtl/arith_unit_mc.sv
// arith_unit_mc: multi-cycle signed ADD/SUB (1 edge), MUL (2-stage), restoring DIV, start/busy handshake
// Ports: CLK/RST (async high); A,B operands; ALU_FUN 0 ADD 1 SUB 2 MUL 3 DIV; Arith_EN start;
//        Busy in flight; Arith_OUT result {rem,quo} for DIV; Arith_Flag one-cycle valid;
//        Carry_OUT carry/borrow; Overflow signed/DIV overflow; Div_Zero divide by zero.
module arith_unit_mc #(
    parameter int WIDTH = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         ALU_FUN,
    input  logic               Arith_EN,
    output logic               Busy,
    output logic [2*WIDTH-1:0] Arith_OUT,
    output logic               Arith_Flag,
    output logic               Carry_OUT,
    output logic               Overflow,
    output logic               Div_Zero
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, dv_q, dv_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           qneg_q, qneg_d, rneg_q, rneg_d, ovf_q, ovf_d;
    logic [2*W-1:0] out_q, out_d, prod;
    logic           cy_q, cy_d, ov_q, ov_d, dz_q, dz_d, flag_q, flag_d;
    logic [W:0]     add_x, sub_x, res_x, add_u;
    logic [W-1:0]   mag_a, mag_b;

    // One restoring step: shift the next dividend bit into the partial remainder.
    // The remainder always stays below the divisor, so W bits are enough to hold it.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem, quo, dv);
        logic [W:0] t, r;
        logic       ge;
        t  = {rem, quo[W-1]};
        ge = t >= {1'b0, dv};
        r  = ge ? t - {1'b0, dv} : t;
        return {r[W-1:0], quo[W-2:0], ge};
    endfunction

    assign add_x = {A[W-1], A} + {B[W-1], B};
    assign sub_x = {A[W-1], A} - {B[W-1], B};
    assign add_u = {1'b0, A} + {1'b0, B};
    assign res_x = ALU_FUN[0] ? sub_x : add_x;
    assign mag_a = A[W-1] ? -A : A;
    assign mag_b = B[W-1] ? -B : B;
    assign prod  = {{W{a_q[W-1]}}, a_q} * {{W{b_q[W-1]}}, b_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dv_d    = dv_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        ovf_d   = ovf_q;
        out_d   = out_q;
        cy_d    = cy_q;
        ov_d    = ov_q;
        dz_d    = dz_q;
        flag_d  = 1'b0;
        case (state_q)
            IDLE: if (Arith_EN) begin
                case (ALU_FUN)
                    2'd0, 2'd1: begin
                        out_d  = {{(W-1){res_x[W]}}, res_x};
                        cy_d   = ALU_FUN[0] ? (A < B) : add_u[W];
                        ov_d   = res_x[W] != res_x[W-1];
                        dz_d   = 1'b0;
                        flag_d = 1'b1;
                    end
                    2'd2: begin
                        a_d     = A;
                        b_d     = B;
                        state_d = MUL;
                    end
                    default: if (B == '0) begin
                        out_d  = '0;
                        cy_d   = 1'b0;
                        ov_d   = 1'b0;
                        dz_d   = 1'b1;
                        flag_d = 1'b1;
                    end else begin
                        // The accept edge loads the magnitudes and already performs the first iteration.
                        {rem_d, quo_d} = div_step('0, mag_a, mag_b);
                        dv_d    = mag_b;
                        cnt_d   = CW'(1);
                        qneg_d  = A[W-1] ^ B[W-1];
                        rneg_d  = A[W-1];
                        ovf_d   = (A == {1'b1, {(W-1){1'b0}}}) && (&B);
                        state_d = DIV;
                    end
                endcase
            end
            MUL: begin
                out_d   = prod;
                cy_d    = 1'b0;
                ov_d    = 1'b0;
                dz_d    = 1'b0;
                flag_d  = 1'b1;
                state_d = IDLE;
            end
            DIV: begin
                {rem_d, quo_d} = div_step(rem_q, quo_q, dv_q);
                cnt_d   = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(W-1)) ? FIX : DIV;
            end
            default: begin
                out_d   = {rneg_q ? -rem_q : rem_q, qneg_q ? -quo_q : quo_q};
                cy_d    = 1'b0;
                ov_d    = ovf_q;
                dz_d    = 1'b0;
                flag_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            cy_q    <= 1'b0;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            cy_q    <= cy_d;
            ov_q    <= ov_d;
            dz_q    <= dz_d;
            flag_q  <= flag_d;
        end
    end

    assign Busy       = state_q != IDLE;
    assign Arith_OUT  = out_q;
    assign Arith_Flag = flag_q;
    assign Carry_OUT  = cy_q;
    assign Overflow   = ov_q;
    assign Div_Zero   = dz_q;
endmodule

// File: tb/tb_arith_unit_mc.sv
// tb_arith_unit_mc: directed vectors with a queue scoreboard checked by a separate flag monitor
module tb_arith_unit_mc;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] A = '0, B = '0;
    logic [1:0]  ALU_FUN = '0;
    logic        Arith_EN = 1'b0;
    logic        Busy, Arith_Flag, Carry_OUT, Overflow, Div_Zero;
    logic [31:0] Arith_OUT;

    typedef struct {
        logic [31:0] out;
        logic        cy, ov, dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    arith_unit_mc #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .Arith_EN(Arith_EN),
        .Busy(Busy), .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag),
        .Carry_OUT(Carry_OUT), .Overflow(Overflow), .Div_Zero(Div_Zero)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every result pulse must match the oldest outstanding expectation, on the expected edge.
    always @(negedge CLK) begin
        if (Arith_Flag) begin
            if (sb.size() == 0) begin
                chk("unexpected_flag", 64'(Arith_Flag), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("arith_out", 64'(Arith_OUT), 64'(e.out));
                chk("carry", 64'(Carry_OUT), 64'(e.cy));
                chk("overflow", 64'(Overflow), 64'(e.ov));
                chk("div_zero", 64'(Div_Zero), 64'(e.dz));
                chk("latency_edge", 64'(cyc), 64'(e.due));
                chk("busy_in_flag", 64'(Busy), 64'd0);
            end
        end
    end

    // lat = edges from the last edge before acceptance to the edge raising Arith_Flag.
    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] out, input logic cy, input logic ov, input logic dz,
                         input int lat, input int busy_n, input bit poke);
        int n;
        @(negedge CLK);
        ALU_FUN = op; A = a; B = b; Arith_EN = 1'b1;
        sb.push_back('{out, cy, ov, dz, cyc + lat});
        @(posedge CLK);
        #1;
        Arith_EN = 1'b0;
        A = 16'($urandom);
        B = 16'($urandom);
        ALU_FUN = 2'($urandom);
        n = 0;
        @(negedge CLK);
        while (Busy && n < 40) begin
            if (poke && n == 2) begin
                Arith_EN = 1'b1; ALU_FUN = 2'd0; A = 16'd1; B = 16'd1;
            end
            n++;
            @(negedge CLK);
            Arith_EN = 1'b0;
        end
        chk("busy_cycles", 64'(n), 64'(busy_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_out", 64'(Arith_OUT), 64'd0);
        chk("rst_flags", 64'({Busy, Arith_Flag, Carry_OUT, Overflow, Div_Zero}), 64'd0);
        RST = 1'b0;

        issue(2'd0, 16'h7FFF, 16'h0001, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        issue(2'd1, 16'd3, 16'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
        issue(2'd0, 16'hFFFF, 16'h0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1, 0, 1'b0);
        issue(2'd1, 16'h8000, 16'h0001, 32'hFFFF_7FFF, 1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        issue(2'd2, 16'hFED4, 16'd200, 32'hFFFF_15A0, 1'b0, 1'b0, 1'b0, 2, 1, 1'b0);
        issue(2'd2, 16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 2, 1, 1'b0);
        issue(2'd3, 16'hFFF9, 16'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 17, 16, 1'b1);
        issue(2'd3, 16'd5, 16'd0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1, 0, 1'b0);
        issue(2'd3, 16'd100, 16'd7, 32'h0002_000E, 1'b0, 1'b0, 1'b0, 17, 16, 1'b0);
        issue(2'd3, 16'd7, 16'hFFFE, 32'h0001_FFFD, 1'b0, 1'b0, 1'b0, 17, 16, 1'b0);

        // Back-to-back requests: EN held high across three consecutive edges.
        @(negedge CLK);
        ALU_FUN = 2'd0; A = 16'd1; B = 16'd2; Arith_EN = 1'b1;
        sb.push_back('{32'd3, 1'b0, 1'b0, 1'b0, cyc + 1});
        @(posedge CLK);
        #1;
        A = 16'h0010; B = 16'h0020;
        sb.push_back('{32'h30, 1'b0, 1'b0, 1'b0, cyc + 1});
        @(posedge CLK);
        #1;
        ALU_FUN = 2'd1; A = 16'd0; B = 16'd1;
        sb.push_back('{32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, cyc + 1});
        @(posedge CLK);
        #1;
        Arith_EN = 1'b0;
        repeat (2) @(negedge CLK);

        issue(2'd3, 16'h8000, 16'hFFFF, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 17, 16, 1'b0);

        // Reset in the middle of a divide: outputs clear at once, no result pulse follows.
        @(negedge CLK);
        ALU_FUN = 2'd3; A = 16'd100; B = 16'd7; Arith_EN = 1'b1;
        @(posedge CLK);
        #1;
        Arith_EN = 1'b0;
        repeat (7) @(negedge CLK);
        chk("busy_before_rst", 64'(Busy), 64'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_mid_out", 64'(Arith_OUT), 64'd0);
        chk("rst_mid_flags", 64'({Busy, Arith_Flag, Carry_OUT, Overflow, Div_Zero}), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        chk("no_flag_after_rst", 64'(Busy), 64'd0);

        issue(2'd0, 16'd1, 16'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0);

        repeat (3) @(negedge CLK);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
